// File: rtl/i2cmb_byte_fsm.sv
// Byte-level command engine of the i2cmb: expands byte commands into bit-engine requests.
// Optional saturating statistics counters are built when I2CMB_BYTE_FSM_STATS_EN is defined.
module i2cmb_byte_fsm #(
    parameter int unsigned NUM_BUSES  = 16,
    parameter int unsigned WAIT_TICKS = 1000,
    localparam int unsigned BUS_W     = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_code_i,
    input  logic [7:0]       cmd_data_i,
    output logic             rsp_valid_o,
    output logic [1:0]       rsp_code_o,
    output logic [7:0]       rd_data_o,
    output logic [BUS_W-1:0] bus_id_o,
    output logic             bus_captured_o,
    output logic             bit_req_o,
    output logic [1:0]       bit_op_o,
    output logic             bit_wdata_o,
    input  logic             bit_done_i,
    input  logic             bit_rdata_i,
    input  logic             bit_al_i,
    output logic [15:0]      stat_bytes_o,
    output logic [15:0]      stat_naks_o
);

    localparam int unsigned WAIT_MAX = 255 * WAIT_TICKS;
    localparam int unsigned CNT_RAW  = $clog2(WAIT_MAX + 1);
    localparam int unsigned CNT_W    = (CNT_RAW < 18) ? 18 : CNT_RAW;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_STOP     = 4'd2;
    localparam logic [3:0] S_WR_BIT   = 4'd3;
    localparam logic [3:0] S_WR_ACK   = 4'd4;
    localparam logic [3:0] S_RD_BIT   = 4'd5;
    localparam logic [3:0] S_RD_ACK   = 4'd6;
    localparam logic [3:0] S_WAIT_CNT = 4'd7;
    localparam logic [3:0] S_RESP     = 4'd8;

    localparam logic [2:0] C_START    = 3'd0;
    localparam logic [2:0] C_STOP     = 3'd1;
    localparam logic [2:0] C_READ_ACK = 3'd2;
    localparam logic [2:0] C_READ_NAK = 3'd3;
    localparam logic [2:0] C_WRITE    = 3'd4;
    localparam logic [2:0] C_SET_BUS  = 3'd5;
    localparam logic [2:0] C_WAIT     = 3'd6;

    localparam logic [1:0] R_DON = 2'd0;
    localparam logic [1:0] R_NAK = 2'd1;
    localparam logic [1:0] R_AL  = 2'd2;
    localparam logic [1:0] R_ERR = 2'd3;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WR    = 2'd2;
    localparam logic [1:0] OP_RD    = 2'd3;

    logic [3:0]       state_q, state_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_code_q, rsp_code_d;
    logic [1:0]       res_q, res_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [7:0]       rd_shift_q, rd_shift_d;
    logic [7:0]       wr_shift_q, wr_shift_d;
    logic             rd_nak_q, rd_nak_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BUS_W-1:0] bus_id_q, bus_id_d;
    logic             captured_q, captured_d;
    logic             bit_req_q, bit_req_d;
    logic [1:0]       bit_op_q, bit_op_d;
    logic             bit_wdata_q, bit_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_state_c;
    logic [1:0]       op_c;
    logic             wd_c;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= R_DON;
            res_q       <= R_DON;
            rd_data_q   <= 8'h00;
            rd_shift_q  <= 8'h00;
            wr_shift_q  <= 8'h00;
            rd_nak_q    <= 1'b0;
            bit_cnt_q   <= 3'd0;
            bus_id_q    <= '0;
            captured_q  <= 1'b0;
            bit_req_q   <= 1'b0;
            bit_op_q    <= OP_START;
            bit_wdata_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            res_q       <= res_d;
            rd_data_q   <= rd_data_d;
            rd_shift_q  <= rd_shift_d;
            wr_shift_q  <= wr_shift_d;
            rd_nak_q    <= rd_nak_d;
            bit_cnt_q   <= bit_cnt_d;
            bus_id_q    <= bus_id_d;
            captured_q  <= captured_d;
            bit_req_q   <= bit_req_d;
            bit_op_q    <= bit_op_d;
            bit_wdata_q <= bit_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_code_d  = rsp_code_q;
        res_d       = res_q;
        rd_data_d   = rd_data_q;
        rd_shift_d  = rd_shift_q;
        wr_shift_d  = wr_shift_q;
        rd_nak_d    = rd_nak_q;
        bit_cnt_d   = bit_cnt_q;
        bus_id_d    = bus_id_q;
        captured_d  = captured_q;
        bit_req_d   = bit_req_q;
        bit_op_d    = bit_op_q;
        bit_wdata_d = bit_wdata_q;
        cnt_d       = cnt_q;
        op_c        = OP_START;
        wd_c        = 1'b0;
        bit_state_c = 1'b0;

        case (state_q)
            S_START:  begin bit_state_c = 1'b1; op_c = OP_START; end
            S_STOP:   begin bit_state_c = 1'b1; op_c = OP_STOP; end
            S_WR_BIT: begin bit_state_c = 1'b1; op_c = OP_WR; wd_c = wr_shift_q[7]; end
            S_WR_ACK: begin bit_state_c = 1'b1; op_c = OP_RD; end
            S_RD_BIT: begin bit_state_c = 1'b1; op_c = OP_RD; end
            S_RD_ACK: begin bit_state_c = 1'b1; op_c = OP_WR; wd_c = rd_nak_q; end
            default:  ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    wr_shift_d = cmd_data_i;
                    rd_nak_d   = (cmd_code_i == C_READ_NAK);
                    bit_cnt_d  = 3'd0;
                    cnt_d      = '0;
                    res_d      = R_ERR;
                    // Commands with no bit ops reuse WAIT_CNT with a zero count
                    state_d    = S_WAIT_CNT;
                    case (cmd_code_i)
                        C_START: begin
                            state_d = S_START;
                            res_d   = R_DON;
                        end
                        C_STOP:  if (captured_q) state_d = S_STOP;
                        C_READ_ACK, C_READ_NAK: if (captured_q) state_d = S_RD_BIT;
                        C_WRITE: if (captured_q) state_d = S_WR_BIT;
                        C_SET_BUS: begin
                            if ((32'(cmd_data_i) < NUM_BUSES) && !captured_q) begin
                                bus_id_d = BUS_W'(cmd_data_i);
                                res_d    = R_DON;
                            end
                        end
                        C_WAIT: begin
                            if (!captured_q) begin
                                cnt_d = CNT_W'(cmd_data_i) * CNT_W'(WAIT_TICKS);
                                res_d = R_DON;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_WAIT_CNT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                rsp_code_d  = res_q;
                state_d     = S_IDLE;
            end
            default: ;
        endcase

        if (bit_state_c) begin
            if (!bit_req_q) begin
                bit_req_d   = 1'b1;
                bit_op_d    = op_c;
                bit_wdata_d = wd_c;
            end else if (bit_done_i) begin
                bit_req_d = 1'b0;
                if (bit_al_i) begin
                    res_d      = R_AL;
                    captured_d = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    case (state_q)
                        S_START: begin
                            captured_d = 1'b1;
                            res_d      = R_DON;
                            state_d    = S_RESP;
                        end
                        S_STOP: begin
                            captured_d = 1'b0;
                            res_d      = R_DON;
                            state_d    = S_RESP;
                        end
                        S_WR_BIT: begin
                            wr_shift_d = {wr_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_d = S_WR_ACK;
                        end
                        S_WR_ACK: begin
                            res_d   = bit_rdata_i ? R_NAK : R_DON;
                            state_d = S_RESP;
                        end
                        S_RD_BIT: begin
                            rd_shift_d = {rd_shift_q[6:0], bit_rdata_i};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) state_d = S_RD_ACK;
                        end
                        S_RD_ACK: begin
                            rd_data_d = rd_shift_q;
                            res_d     = R_DON;
                            state_d   = S_RESP;
                        end
                        default: ;
                    endcase
                end
            end
        end

        // Ready stays low through the response cycle and rises one cycle later
        cmd_ready_d = (state_d == S_IDLE) && (state_q != S_RESP);
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_code_o     = rsp_code_q;
    assign rd_data_o      = rd_data_q;
    assign bus_id_o       = bus_id_q;
    assign bus_captured_o = captured_q;
    assign bit_req_o      = bit_req_q;
    assign bit_op_o       = bit_op_q;
    assign bit_wdata_o    = bit_wdata_q;

`ifdef I2CMB_BYTE_FSM_STATS_EN
    logic [15:0] stat_bytes_q;
    logic [15:0] stat_naks_q;
    logic        byte_end_c;
    logic        nak_c;

    // A byte counts when its ack phase completes without arbitration loss
    assign byte_end_c = bit_req_q && bit_done_i && !bit_al_i &&
                        ((state_q == S_WR_ACK) || (state_q == S_RD_ACK));
    assign nak_c      = byte_end_c && (state_q == S_WR_ACK) && bit_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bytes_q <= 16'h0000;
            stat_naks_q  <= 16'h0000;
        end else begin
            if (byte_end_c && (stat_bytes_q != 16'hFFFF)) stat_bytes_q <= stat_bytes_q + 16'd1;
            if (nak_c && (stat_naks_q != 16'hFFFF)) stat_naks_q <= stat_naks_q + 16'd1;
        end
    end

    assign stat_bytes_o = stat_bytes_q;
    assign stat_naks_o  = stat_naks_q;
`else
    assign stat_bytes_o = 16'h0000;
    assign stat_naks_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_i2cmb_byte_fsm.sv
// Bench for i2cmb_byte_fsm: command vector table, bit-engine model and response scoreboard.
module tb_i2cmb_byte_fsm;

    localparam int unsigned NUM_BUSES  = 16;
    localparam int unsigned WAIT_TICKS = 1000;

    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_RDA = 3'd2, C_RDN = 3'd3;
    localparam logic [2:0] C_WR = 3'd4, C_SB = 3'd5, C_WT = 3'd6, C_RSV = 3'd7;
    localparam logic [1:0] R_DON = 2'd0, R_NAK = 2'd1, R_AL = 2'd2, R_ERR = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_code = 3'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic [7:0]  rd_data;
    logic [3:0]  bus_id;
    logic        bus_captured;
    logic        bit_req;
    logic [1:0]  bit_op;
    logic        bit_wdata;
    logic        bit_done = 1'b0;
    logic        bit_rdata = 1'b0;
    logic        bit_al = 1'b0;
    logic [15:0] stat_bytes;
    logic [15:0] stat_naks;

    i2cmb_byte_fsm #(.NUM_BUSES(NUM_BUSES), .WAIT_TICKS(WAIT_TICKS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_code_i(cmd_code), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_code_o(rsp_code), .rd_data_o(rd_data),
        .bus_id_o(bus_id), .bus_captured_o(bus_captured),
        .bit_req_o(bit_req), .bit_op_o(bit_op), .bit_wdata_o(bit_wdata),
        .bit_done_i(bit_done), .bit_rdata_i(bit_rdata), .bit_al_i(bit_al),
        .stat_bytes_o(stat_bytes), .stat_naks_o(stat_naks)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected responses
    typedef struct {
        logic [1:0] code;
        logic [7:0] rd;
        int         lat;
        int         acc_cyc;
    } exp_t;
    exp_t sb_q[$];
    int   rsp_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            exp_t e;
            rsp_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_code), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("rsp_code", 32'(rsp_code), 32'(e.code));
                check("rd_data", 32'(rd_data), 32'(e.rd));
                check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    // Bit-engine model
    typedef struct { logic [1:0] op; logic wd; } bop_t;
    bop_t op_log[$];
    logic rd_bits_q[$];
    int   eng_lat = 1;
    int   al_on_op = 0;
    int   op_n = 0;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_n && bit_req) begin
                op_log.push_back('{bit_op, bit_wdata});
                op_n++;
                for (int k = 1; k < eng_lat; k++) begin
                    @(posedge clk); #1;
                end
                if (rst_n && bit_req) begin
                    bit_done  = 1'b1;
                    bit_rdata = 1'b0;
                    if (bit_op == 2'd3 && rd_bits_q.size() > 0) bit_rdata = rd_bits_q.pop_front();
                    bit_al = (op_n == al_on_op);
                    @(posedge clk); #1;
                    bit_done  = 1'b0;
                    bit_al    = 1'b0;
                    bit_rdata = 1'b0;
                end
            end
        end
    end

    task automatic issue_cmd(input logic [2:0] code, input logic [7:0] data,
                             input logic [1:0] exp_code, input logic [7:0] exp_rd, input int exp_lat);
        exp_t e;
        int g = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_data  = data;
        while (!cmd_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        e.code = exp_code; e.rd = exp_rd; e.lat = exp_lat; e.acc_cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_rsp(input int start_cnt, input int budget);
        int g = 0;
        while (rsp_cnt == start_cnt && g < budget) begin
            @(posedge clk); #1;
            g++;
        end
        check("rsp_arrived", 32'(rsp_cnt - start_cnt), 32'd1);
    endtask

    task automatic run_cmd(input logic [2:0] code, input logic [7:0] data,
                           input logic [1:0] exp_code, input logic [7:0] exp_rd, input int exp_lat);
        int s;
        s = rsp_cnt;
        issue_cmd(code, data, exp_code, exp_rd, exp_lat);
        wait_rsp(s, exp_lat + 40);
    endtask

    task automatic exp_bitop(input logic [2:0] code, input logic [7:0] data, input int k,
                             output logic [1:0] op, output logic wd, output logic care);
        op = 2'd0; wd = 1'b0; care = 1'b0;
        case (code)
            C_START: op = 2'd0;
            C_STOP:  op = 2'd1;
            C_WR: begin
                if (k < 8) begin op = 2'd2; wd = data[7-k]; care = 1'b1; end
                else op = 2'd3;
            end
            default: begin
                if (k < 8) op = 2'd3;
                else begin op = 2'd2; wd = (code == C_RDN); care = 1'b1; end
            end
        endcase
    endtask

    typedef struct {
        logic [2:0] code;
        logic [7:0] data;
        logic [7:0] rbits;
        int         lat_eng;
        int         al_op;
        logic [1:0] exp_code;
        logic [3:0] exp_bus;
        logic       exp_cap;
        int         exp_ops;
    } vec_t;
    vec_t vt[$];
    vec_t v;
    logic [7:0] exp_rd = 8'h00;
    int exp_bytes = 0;
    int exp_naks = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, errs, s;
        logic [1:0] eop;
        logic ewd, ecare;

        vt.push_back('{C_SB,    8'd3,   8'h00, 1, 0, R_DON, 4'd3,  1'b0, 0});
        vt.push_back('{C_SB,    8'd16,  8'h00, 1, 0, R_ERR, 4'd3,  1'b0, 0});
        vt.push_back('{C_WR,    8'h5A,  8'h00, 1, 0, R_ERR, 4'd3,  1'b0, 0});
        vt.push_back('{C_STOP,  8'h00,  8'h00, 1, 0, R_ERR, 4'd3,  1'b0, 0});
        vt.push_back('{C_RSV,   8'h00,  8'h00, 1, 0, R_ERR, 4'd3,  1'b0, 0});
        vt.push_back('{C_RDA,   8'h00,  8'h00, 1, 0, R_ERR, 4'd3,  1'b0, 0});
        vt.push_back('{C_WT,    8'd0,   8'h00, 1, 0, R_DON, 4'd3,  1'b0, 0});
        vt.push_back('{C_START, 8'h00,  8'h00, 1, 0, R_DON, 4'd3,  1'b1, 1});
        vt.push_back('{C_WR,    8'hA5,  8'h00, 1, 0, R_DON, 4'd3,  1'b1, 9});
        vt.push_back('{C_SB,    8'd2,   8'h00, 1, 0, R_ERR, 4'd3,  1'b1, 0});
        vt.push_back('{C_WT,    8'd2,   8'h00, 1, 0, R_ERR, 4'd3,  1'b1, 0});
        vt.push_back('{C_RDN,   8'h00,  8'hC3, 2, 0, R_DON, 4'd3,  1'b1, 9});
        vt.push_back('{C_WR,    8'h3C,  8'h01, 1, 0, R_NAK, 4'd3,  1'b1, 9});
        vt.push_back('{C_START, 8'h00,  8'h00, 3, 0, R_DON, 4'd3,  1'b1, 1});
        vt.push_back('{C_RDA,   8'h00,  8'h5A, 1, 0, R_DON, 4'd3,  1'b1, 9});
        vt.push_back('{C_STOP,  8'h00,  8'h00, 1, 0, R_DON, 4'd3,  1'b0, 1});
        vt.push_back('{C_START, 8'h00,  8'h00, 1, 0, R_DON, 4'd3,  1'b1, 1});
        vt.push_back('{C_WR,    8'hFF,  8'h00, 1, 3, R_AL,  4'd3,  1'b0, 3});
        vt.push_back('{C_WR,    8'h00,  8'h00, 1, 0, R_ERR, 4'd3,  1'b0, 0});
        vt.push_back('{C_SB,    8'd15,  8'h00, 1, 0, R_DON, 4'd15, 1'b0, 0});
        vt.push_back('{C_WT,    8'd2,   8'h00, 1, 0, R_DON, 4'd15, 1'b0, 0});

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_code", 32'(rsp_code), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_bus_id", 32'(bus_id), 32'd0);
        check("rst_captured", 32'(bus_captured), 32'd0);
        check("rst_bit_req", 32'({bit_req, bit_op, bit_wdata}), 32'd0);
        check("rst_stats", {stat_bytes, stat_naks}, 32'd0);

        foreach (vt[i]) begin
            v = vt[i];
            eng_lat  = v.lat_eng;
            al_on_op = v.al_op;
            op_log.delete();
            rd_bits_q.delete();
            op_n = 0;
            if (v.code == C_RDA || v.code == C_RDN) begin
                for (int b = 7; b >= 0; b--) rd_bits_q.push_back(v.rbits[b]);
            end else if (v.code == C_WR) begin
                rd_bits_q.push_back(v.rbits[0]);
            end
            if (v.code == C_WT && v.exp_code == R_DON) lat = int'(v.data) * int'(WAIT_TICKS) + 2;
            else if (v.exp_ops == 0) lat = 2;
            else lat = v.exp_ops * v.lat_eng + (v.exp_ops - 1) + 2;
            if ((v.code == C_RDA || v.code == C_RDN) && v.exp_code == R_DON) exp_rd = v.rbits;
            if ((v.code == C_WR || v.code == C_RDA || v.code == C_RDN) &&
                (v.exp_code == R_DON || v.exp_code == R_NAK)) exp_bytes++;
            if (v.exp_code == R_NAK) exp_naks++;

            run_cmd(v.code, v.data, v.exp_code, exp_rd, lat);

            check($sformatf("v%0d_bus_id", i), 32'(bus_id), 32'(v.exp_bus));
            check($sformatf("v%0d_captured", i), 32'(bus_captured), 32'(v.exp_cap));
            check($sformatf("v%0d_nops", i), 32'(op_log.size()), 32'(v.exp_ops));
            errs = 0;
            for (int k = 0; k < op_log.size() && k < v.exp_ops; k++) begin
                exp_bitop(v.code, v.data, k, eop, ewd, ecare);
                if (op_log[k].op !== eop) errs++;
                if (ecare && op_log[k].wd !== ewd) errs++;
            end
            check($sformatf("v%0d_bitseq_errs", i), 32'(errs), 32'd0);
        end

`ifdef I2CMB_BYTE_FSM_STATS_EN
        check("stat_bytes", 32'(stat_bytes), 32'(exp_bytes));
        check("stat_naks", 32'(stat_naks), 32'(exp_naks));
`else
        check("stat_bytes_tied", 32'(stat_bytes), 32'd0);
        check("stat_naks_tied", 32'(stat_naks), 32'd0);
`endif

        // Reset in the middle of a READ: abort with no response
        eng_lat = 1; al_on_op = 0;
        run_cmd(C_START, 8'h00, R_DON, exp_rd, 3);
        eng_lat = 3; op_log.delete(); op_n = 0;
        for (int b = 0; b < 8; b++) rd_bits_q.push_back(1'b1);
        s = rsp_cnt;
        issue_cmd(C_RDA, 8'h00, R_DON, 8'hFF, 0);
        repeat (9) @(posedge clk);
        #1;
        check("midread_ops_started", 32'(op_n > 0), 32'd1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        rd_bits_q.delete();
        check("midrst_bit_req", 32'({bit_req, bit_op, bit_wdata}), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_rsp", 32'({rsp_valid, rsp_code}), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_bus", 32'({bus_id, bus_captured}), 32'd0);
        check("midrst_stats", {stat_bytes, stat_naks}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        eng_lat = 1;
        repeat (20) @(posedge clk);
        #1;
        check("no_rsp_after_abort", 32'(rsp_cnt - s), 32'd0);
        check("post_rst_bit_req", 32'(bit_req), 32'd0);
        run_cmd(C_SB, 8'd1, R_DON, 8'h00, 2);
        check("post_rst_bus_id", 32'(bus_id), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
